// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: default slot width, bit-clock
// divider and the frame length derived from the slot width.
package i2s_pkg;

    localparam int DATA_SIZE_DEF  = 16;
    localparam int CLK_DIV_DEF    = 8;
    localparam int FRAME_BITS_DEF = 2 * DATA_SIZE_DEF;

    // A frame carries one left and one right slot back to back.
    function automatic int frame_len(input int data_size);
        return 2 * data_size;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk down to i2s_sck and flags the cycle in
// which i2s_sck is about to fall, so the data path can update on it.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic i2s_sck,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap      = (div_cnt == CW'(CLK_DIV - 1));
    assign fall_tick = wrap && i2s_sck;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            i2s_sck <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            i2s_sck <= ~i2s_sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/transmitter_i2s.sv
// I2S transmitter: one-deep holding register for a stereo pair, loaded into a
// frame-wide shift register at each frame start and sent MSB first.
module transmitter_i2s
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] audio_left,
    input  logic [DATA_SIZE-1:0] audio_right,
    input  logic                 valid,
    output logic                 ready,
    output logic                 i2s_sck,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun
);

    localparam int FRAME = frame_len(DATA_SIZE);
    localparam int BW    = $clog2(FRAME);

    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
    localparam logic [BW-1:0] WS_FIRST = BW'(DATA_SIZE - 1);
    localparam logic [BW-1:0] WS_LAST  = BW'(FRAME - 2);

    logic                 fall_tick;
    logic                 frame_start;
    logic                 accept;
    logic                 hold_full;
    logic [DATA_SIZE-1:0] hold_left;
    logic [DATA_SIZE-1:0] hold_right;
    logic [FRAME-1:0]     frame_word;
    logic [FRAME-1:0]     shift_reg;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_next;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .i2s_sck   (i2s_sck),
        .fall_tick (fall_tick)
    );

    assign frame_start = fall_tick && (bit_idx == LAST_BIT);
    assign ready       = !hold_full;
    assign accept      = valid && !hold_full;
    assign underrun    = frame_start && !hold_full;
    assign bit_next    = (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
    assign frame_word  = hold_full ? {hold_left, hold_right} : '0;

    // A frame start drains a full register; an empty one may accept in the
    // same cycle, and that pair waits for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
        end else if (frame_start && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end
    end

    // NOTE: the held sample words carry no reset; hold_full alone decides
    // whether they are ever used, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_left  <= audio_left;
            hold_right <= audio_right;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= LAST_BIT;
            shift_reg <= '0;
            i2s_sd    <= 1'b0;
            i2s_ws    <= 1'b0;
        end else if (fall_tick) begin
            bit_idx <= bit_next;
            // WS switches one bit ahead of the slot it announces.
            i2s_ws  <= (bit_next >= WS_FIRST) && (bit_next <= WS_LAST);
            if (frame_start) begin
                i2s_sd    <= frame_word[FRAME-1];
                shift_reg <= {frame_word[FRAME-2:0], 1'b0};
            end else begin
                i2s_sd    <= shift_reg[FRAME-1];
                shift_reg <= {shift_reg[FRAME-2:0], 1'b0};
            end
        end
    end

endmodule

// File: doc/transmitter_i2s.md
TRANSMITTER_I2S -- requirements
Module: transmitter_i2s

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16: bits per channel slot.
REQ-002 SHALL have parameter CLK_DIV, default 8: clk cycles per i2s_sck half-period (≥1).
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port audio_left  input  DATA_SIZE: left sample, two's complement.
REQ-006 SHALL have port audio_right  input  DATA_SIZE: right sample, two's complement.
REQ-007 SHALL have port valid  input  1: the audio_left/audio_right pair is offered.
REQ-008 SHALL have port ready  output  1: holding register empty; a pair is accepted when valid && ready.
REQ-009 SHALL have port i2s_sck  output  1: serial bit clock.
REQ-010 SHALL have port i2s_ws  output  1: word select; 0 = left, 1 = right.
REQ-011 SHALL have port i2s_sd  output  1: serial data, MSB first.
REQ-012 SHALL have port underrun  output  1: one-clk pulse when a frame starts with no sample available.

Function
REQ-013 Divider SHALL count 0..CLK_DIV-1 and toggle i2s_sck on the cycle it wraps; sck period = 2*CLK_DIV clk.
REQ-014 "fall tick" SHALL be the clk cycle in which i2s_sck toggles 1->0; i2s_ws and i2s_sd SHALL change only on fall ticks.
REQ-015 Bit index b SHALL advance on each fall tick over 0..2*DATA_SIZE-1 and wrap to 0.
REQ-016 i2s_sd SHALL carry left bit DATA_SIZE-1-b for b < DATA_SIZE, and right bit 2*DATA_SIZE-1-b otherwise.
REQ-017 i2s_ws SHALL be 1 for b in [DATA_SIZE-1, 2*DATA_SIZE-2] and 0 otherwise, so WS leads its MSB by one bit (standard I2S).
REQ-018 Frame start SHALL be the fall tick entering b=0: if the holding register is full, its pair SHALL load the 2*DATA_SIZE shift register, the holding register SHALL become empty, and ready SHALL rise on the next cycle.
REQ-019 If the holding register is empty at frame start, the shift register SHALL load all zeros and underrun SHALL pulse high for exactly that one cycle.
REQ-020 valid && ready SHALL capture both channels into the holding register; ready SHALL be 0 from the next cycle until the next frame start.
REQ-021 Acceptance in the same cycle as an empty-holding frame start SHALL still produce underrun and a zero frame; the captured pair SHALL transmit in the following frame.
REQ-022 While ready is 0, valid and the data inputs SHALL be ignored; the held pair SHALL NOT be overwritten.
REQ-023 underrun SHALL NOT depend on valid in cycles other than frame start.

Reset
REQ-024 While rst is 1: i2s_sck=0, i2s_ws=0, i2s_sd=0, underrun=0, ready=1, divider=0, b=2*DATA_SIZE-1, holding empty, shift register zero.
REQ-025 After rst falls, the first fall tick SHALL occur 2*CLK_DIV clk cycles later and SHALL be a frame start.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately and discard any held pair.

Structure
REQ-027 Package i2s_pkg SHALL hold the DATA_SIZE and CLK_DIV defaults and the frame-length constant 2*DATA_SIZE.
REQ-028 The divider SHALL be sub-module i2s_clk_gen, with outputs i2s_sck and fall_tick.
REQ-029 The block SHALL contain no FIFO; upstream buffering is external.

Verification
REQ-030 Reset release, valid held 0 -> i2s_sck period 16 clk; underrun pulses every 512 clk; i2s_sd constantly 0.
REQ-031 One pair, L=16'hA5C3 and R=16'h0F01, accepted before the first frame -> a decoded frame yields L=A5C3 and R=0F01, WS rises at the LSB of L, and no underrun occurs in that frame.
REQ-032 Back-to-back pairs with valid held 1 -> exactly one acceptance per 512 clk; ready low between acceptance and the next frame start; the sample stream decodes without gaps.
REQ-033 Pair offered in the exact frame-start cycle with holding empty -> underrun pulses and the frame is zero; the pair appears in the next frame.
REQ-034 rst asserted at b=20 of a frame with the holding register full -> all outputs at reset values and ready=1; after release, underrun at the first frame start.
REQ-035 Loopback into receiver_i2s (DATA_SIZE=16) with a 100-sample ramp -> receiver audio_data matches the ramp, in order.
